axi_sp_ram: RTL and testbench
=============================

Name: axi_sp_ram

Overview:
- Parametrised AXI4 slave RAM, the next generation after the fixed-ID AXI RAM wrapper.
- Adds true ID pass-through, FIXED/INCR/WRAP bursts and narrow transfers.
- Adds out-of-range error responses and read/write arbitration over one single-port memory array.
- Sits at interconnect slave ports as scratchpad or model memory.

Parameters:
- DATA_WIDTH, 32: data bus width in bits, power of two, ≥ 8.
- ADDR_WIDTH, 16: byte address width.
- STRB_WIDTH, DATA_WIDTH/8: write strobe width.
- ID_WIDTH, 8: AXI ID width.
- DEPTH, 1024: memory depth in words, power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_awid  in  ID_WIDTH  write ID
- s_axi_awaddr  in  ADDR_WIDTH  write byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awsize  in  3  log2 bytes per beat
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_awvalid  in  1;  s_axi_awready  out  1
- s_axi_wdata  in  DATA_WIDTH;  s_axi_wstrb  in  STRB_WIDTH;  s_axi_wlast  in  1
- s_axi_wvalid  in  1;  s_axi_wready  out  1
- s_axi_bid  out  ID_WIDTH;  s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid  in  (widths as AW);  s_axi_arready  out  1
- s_axi_rid  out  ID_WIDTH;  s_axi_rdata  out  DATA_WIDTH;  s_axi_rresp  out  2;  s_axi_rlast  out  1;  s_axi_rvalid  out  1;  s_axi_rready  in  1

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset:
  - FSM returns to IDLE. All ready/valid outputs are 0; bresp, rresp, rdata, bid, rid, rlast are 0.
  - The last-grant flag resets to "read", so write wins the first tie.
  - Memory contents are not cleared. Reset mid-burst abandons the burst without further memory writes.
- FSM states: IDLE, WRITE, WRESP, READ.
  - IDLE: awready/arready asserted combinationally in IDLE only, for the granted channel.
  - Arbitration: if both valid, grant the channel not served last; otherwise grant the one that is valid.
  - On handshake, latch id/addr/len/size/burst, clear the beat counter and the error flag, then go to WRITE or READ.
- Address generation, per beat:
  - word index = addr >> log2(STRB_WIDTH); increment = 1 << size.
  - FIXED: address constant.
  - INCR: addr += increment.
  - WRAP: boundary = (len+1) << size, valid only for len ∈ {1,3,7,15}; addr wraps to the aligned base when reaching base+boundary. WRAP with any other len is treated as INCR, and the error flag is set.
  - burst 11 is treated as INCR, and the error flag is set.
  - size > log2(STRB_WIDTH) is clamped, and the error flag is set.
- WRITE:
  - wready = 1.
  - Each wvalid beat writes the bytes enabled by wstrb at the current word.
  - Word index ≥ DEPTH: write suppressed, error flag set.
  - Burst ends on the beat where counter == len.
  - If wlast is not coincident with that beat (early or late), the error flag is set. Beats after an early wlast are still consumed up to len.
  - Then go to WRESP.
- WRESP:
  - bvalid = 1; bid = latched id; bresp = 10 (SLVERR) if the error flag is set, else 00.
  - Held stable until bready, then IDLE.
- READ:
  - Synchronous single-port read. AR handshake in cycle T gives first rvalid in T+2.
  - rdata/rid/rresp/rlast are held stable while rvalid && !rready.
  - Next beat's read is issued in the cycle the current beat is accepted, giving 1 beat/cycle throughput with rready high.
  - Out-of-range beat: rdata = 0, rresp = 10. Other beats: rresp = 00, or 10 if a burst-level error is set.
  - rlast = 1 on beat len. Return to IDLE on rlast && rready.
- No simultaneous read and write (single port). An AW arriving during a read waits; no AXI ordering hazards arise.
- len = 0: single beat, rlast and end-of-write on the first beat.

Optional Feature:
- AXI_SP_RAM_RD_PIPE_EN defined:
  - Adds an output register stage on the R channel. First rvalid moves to T+3.
  - A 2-entry skid holds full throughput under backpressure.
- Undefined: latency T+2 as specified in READ, no extra register.

Test Plan:
- INCR write, addr 0x100, len 3, size 2, data 0x11..0x44, all strobes; then INCR read of the same → bresp 00, rdata 0x11,0x22,0x33,0x44, rlast on beat 4, rid = arid = 0x5A, first rvalid 2 cycles after AR handshake.
- WRAP read, addr 0x108, len 3, size 2 → word order 0x108, 0x10C, 0x100, 0x104. WRAP with len 2 → INCR order plus rresp 10.
- Write with wstrb 0b0101 over word 0xDEADBEEF, data 0x12345678 → readback 0xDE34BE78.
- awvalid and arvalid asserted in the same cycle, twice in a row → write granted first, then read on the tie; bid/rid match their requests.
- Address of word DEPTH (0x1000 at default parameters) → write suppressed and bresp 10; read returns rdata 0 with rresp 10; in-range neighbour words unchanged.
- rready toggled 1/0 during an 8-beat read, and rst asserted mid-write burst → R payload stable while stalled; after reset all valids are 0, state IDLE, and no further beats are written.

Source files
------------

// File: rtl/axi_sp_ram.sv
// axi_sp_ram: AXI4 slave RAM over one single-port memory array.
// It passes IDs through and supports FIXED, INCR and WRAP bursts and narrow
// transfers. Out-of-range accesses get SLVERR responses. Reads and writes
// share the array, and an arbiter alternates between them on a tie.
// Optional build macro: AXI_SP_RAM_RD_PIPE_EN adds an R-channel output
// register with a 2-entry skid buffer. This moves the first rvalid one cycle
// later.
module axi_sp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int LOG_STRB = $clog2(STRB_WIDTH);
    localparam int MEM_AW   = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(LOG_STRB);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_WRESP = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state;
    logic                  last_read;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic                  issue_done;

    logic                  grant_write, grant_read, aw_hs, ar_hs;
    logic [7:0]            req_len;
    logic [2:0]            req_size, eff_size;
    logic [1:0]            req_burst, eff_burst;
    logic                  req_err;

    logic [ADDR_WIDTH-1:0] word_idx, incr, wrap_mask, next_addr;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  in_range, last_beat, rfire;

    logic                  core_valid, core_last, core_take, read_done;
    logic [DATA_WIDTH-1:0] core_data;
    logic [1:0]            core_resp;

    assign grant_write   = s_axi_awvalid && (!s_axi_arvalid || last_read);
    assign grant_read    = s_axi_arvalid && !grant_write;
    assign s_axi_awready = (state == ST_IDLE) && grant_write;
    assign s_axi_arready = (state == ST_IDLE) && grant_read;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;

    assign req_len   = grant_write ? s_axi_awlen   : s_axi_arlen;
    assign req_size  = grant_write ? s_axi_awsize  : s_axi_arsize;
    assign req_burst = grant_write ? s_axi_awburst : s_axi_arburst;

    // Turn the request into a legal burst: clamp the size, fall back to INCR for bad bursts, and flag an error
    always_comb begin
        eff_size  = req_size;
        eff_burst = req_burst;
        req_err   = 1'b0;
        if (req_size > MAX_SIZE) begin
            eff_size = MAX_SIZE;
            req_err  = 1'b1;
        end
        if (req_burst == 2'b11) begin
            eff_burst = BURST_INCR;
            req_err   = 1'b1;
        end else if (req_burst == BURST_WRAP &&
                     !(req_len == 8'd1 || req_len == 8'd3 || req_len == 8'd7 || req_len == 8'd15)) begin
            eff_burst = BURST_INCR;
            req_err   = 1'b1;
        end
    end

    assign word_idx  = addr_q >> LOG_STRB;
    assign mem_idx   = word_idx[MEM_AW-1:0];
    assign in_range  = word_idx < DEPTH_A;
    assign incr      = ADDR_WIDTH'(1) << size_q;
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    assign last_beat = (cnt_q == len_q);

    // Compute the address of the next beat from the burst type held in the registers
    always_comb begin
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
            default:     next_addr = addr_q + incr;
        endcase
    end

    assign rfire = (state == ST_READ) && !issue_done && (!core_valid || core_take);

    assign s_axi_wready = (state == ST_WRITE);
    assign s_axi_bvalid = (state == ST_WRESP);
    assign s_axi_bid    = (state == ST_WRESP) ? id_q : '0;
    assign s_axi_bresp  = (state == ST_WRESP && err_q) ? 2'b10 : 2'b00;

    // Control FSM: arbitration, latching the burst, counting beats and tracking errors
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_read  <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= BURST_INCR;
            err_q      <= 1'b0;
            issue_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs || ar_hs) begin
                        id_q       <= grant_write ? s_axi_awid   : s_axi_arid;
                        addr_q     <= grant_write ? s_axi_awaddr : s_axi_araddr;
                        len_q      <= req_len;
                        size_q     <= eff_size;
                        burst_q    <= eff_burst;
                        cnt_q      <= '0;
                        err_q      <= req_err;
                        issue_done <= 1'b0;
                        last_read  <= ar_hs;
                        state      <= aw_hs ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (s_axi_wvalid) begin
                        if (!in_range || (s_axi_wlast != last_beat))
                            err_q <= 1'b1;
                        if (last_beat) begin
                            state <= ST_WRESP;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                ST_WRESP: begin
                    if (s_axi_bready)
                        state <= ST_IDLE;
                end
                default: begin
                    if (rfire) begin
                        if (last_beat) begin
                            issue_done <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                    if (read_done)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-enabled memory write, suppressed out of range and during reset
    always_ff @(posedge clk) begin
        if (!rst && state == ST_WRITE && s_axi_wvalid && in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b])
                    mem[mem_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Synchronous read stage: fetch one beat whenever the stage is empty or being drained
    always_ff @(posedge clk) begin
        if (rst) begin
            core_valid <= 1'b0;
            core_data  <= '0;
            core_resp  <= 2'b00;
            core_last  <= 1'b0;
        end else if (rfire) begin
            core_valid <= 1'b1;
            core_data  <= in_range ? mem[mem_idx] : '0;
            core_resp  <= (!in_range || err_q) ? 2'b10 : 2'b00;
            core_last  <= last_beat;
        end else if (core_take) begin
            core_valid <= 1'b0;
        end
    end

`ifdef AXI_SP_RAM_RD_PIPE_EN
    logic [DATA_WIDTH-1:0] skid_data [2];
    logic [1:0]            skid_resp [2];
    logic                  skid_last [2];
    logic                  wr_ptr, rd_ptr, push, pop;
    logic [1:0]            skid_cnt;

    assign core_take = (skid_cnt != 2'd2);
    assign push      = core_valid && core_take;
    assign pop       = (skid_cnt != 2'd0) && s_axi_rready;

    // Two-entry skid buffer between the read stage and the R channel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                skid_data[i] <= '0;
                skid_resp[i] <= 2'b00;
                skid_last[i] <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            if (push) begin
                skid_data[wr_ptr] <= core_data;
                skid_resp[wr_ptr] <= core_resp;
                skid_last[wr_ptr] <= core_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    assign s_axi_rvalid = (skid_cnt != 2'd0);
    assign s_axi_rdata  = skid_data[rd_ptr];
    assign s_axi_rresp  = skid_resp[rd_ptr];
    assign s_axi_rlast  = skid_last[rd_ptr];
    assign read_done    = pop && skid_last[rd_ptr];
`else
    assign core_take    = s_axi_rready;
    assign s_axi_rvalid = core_valid;
    assign s_axi_rdata  = core_data;
    assign s_axi_rresp  = core_resp;
    assign s_axi_rlast  = core_last;
    assign read_done    = core_valid && s_axi_rready && core_last;
`endif

    assign s_axi_rid = s_axi_rvalid ? id_q : '0;

endmodule

// File: tb/tb_axi_sp_ram.sv
// tb_axi_sp_ram: directed bench for axi_sp_ram at default parameters.
// It covers INCR, WRAP, strobes, the arbiter tie, out-of-range accesses,
// R backpressure and reset in the middle of a write burst.
module tb_axi_sp_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_axi_awid = '0;
    logic [15:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_arid = '0;
    logic [15:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] wbuf    [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [7:0]  rd_id   [16];
    int          rd_lat;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;

    axi_sp_ram dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic seen;
        seen = 1'b0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            #1;
            seen = s_axi_awready;
            tick();
        end
        s_axi_awvalid = 1'b0;
        checkOutput("aw_handshake", 64'(seen), 64'd1);
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic seen;
        seen = 1'b0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            #1;
            seen = s_axi_arready;
            tick();
        end
        s_axi_arvalid = 1'b0;
        checkOutput("ar_handshake", 64'(seen), 64'd1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic seen;
        seen = 1'b0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            #1;
            seen = s_axi_wready;
            tick();
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
        checkOutput("w_handshake", 64'(seen), 64'd1);
    endtask

    task automatic recv_b();
        logic seen;
        seen = 1'b0;
        s_axi_bready = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            #1;
            if (s_axi_bvalid) begin
                seen = 1'b1;
                b_id = s_axi_bid;
                b_resp = s_axi_bresp;
            end
            tick();
        end
        s_axi_bready = 1'b0;
        checkOutput("b_handshake", 64'(seen), 64'd1);
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [15:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb);
        send_aw(id, addr, 8'(len), size, burst);
        for (int i = 0; i <= len; i++)
            send_w(wbuf[i], strb, i == len);
        recv_b();
    endtask

    task automatic collect_r(input int len, input bit toggle);
        int cyc, n;
        logic stalled;
        logic [42:0] held;
        cyc = 1; n = 0; stalled = 1'b0; held = '0; rd_lat = 0;
        while (n <= len && cyc < 200) begin
            s_axi_rready = toggle ? cyc[0] : 1'b1;
            if (s_axi_rvalid) begin
                if (rd_lat == 0)
                    rd_lat = cyc;
                if (stalled)
                    checkOutput("r_stall_payload", 64'({s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}), 64'(held));
                if (s_axi_rready) begin
                    rd_data[n] = s_axi_rdata;
                    rd_resp[n] = s_axi_rresp;
                    rd_last[n] = s_axi_rlast;
                    rd_id[n]   = s_axi_rid;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid};
                end
            end
            tick();
            cyc++;
        end
        s_axi_rready = 1'b0;
        checkOutput("r_beat_count", 64'(n), 64'(len + 1));
    endtask

    task automatic read_burst(input logic [7:0] id, input logic [15:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        send_ar(id, addr, 8'(len), size, burst);
        collect_r(len, toggle);
    endtask

    // Directed sequence; each step checks against hand-computed values
    initial begin
        logic [31:0] exp_words [8];

        $display("[TB] starting axi_sp_ram directed test");
        applyStimulus(3);

        checkOutput("reset_ready_valid",
                    64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 64'd0);
        checkOutput("reset_resp_id", 64'({s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid}), 64'd0);
        checkOutput("reset_rdata", 64'(s_axi_rdata), 64'd0);

        // Tie right after reset: write wins, then read wins the next tie
        s_axi_awid = 8'h21; s_axi_awaddr = 16'h0500; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
        s_axi_arid = 8'h77; s_axi_araddr = 16'h0500; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        #1;
        checkOutput("tie1_grant", 64'({s_axi_awready, s_axi_arready}), 64'b10);
        tick();
        s_axi_awvalid = 1'b0;
        send_w(32'hCAFEF00D, 4'hF, 1'b1);
        recv_b();
        checkOutput("tie1_bid", 64'(b_id), 64'h21);
        checkOutput("tie1_bresp", 64'(b_resp), 64'd0);
        s_axi_awid = 8'h33; s_axi_awaddr = 16'h0504;
        s_axi_awvalid = 1'b1;
        #1;
        checkOutput("tie2_grant", 64'({s_axi_awready, s_axi_arready}), 64'b01);
        tick();
        s_axi_arvalid = 1'b0;
        collect_r(0, 1'b0);
        checkOutput("tie2_rid", 64'(rd_id[0]), 64'h77);
        checkOutput("tie2_rdata", 64'(rd_data[0]), 64'hCAFEF00D);
        checkOutput("tie2_rresp_rlast", 64'({rd_resp[0], rd_last[0]}), 64'b001);
        send_aw(8'h33, 16'h0504, 8'd0, 3'd2, 2'b01);
        send_w(32'h0BEEF001, 4'hF, 1'b1);
        recv_b();
        checkOutput("tie2_bid", 64'(b_id), 64'h33);

        // INCR write then INCR read of the same four words
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        write_burst(8'h3C, 16'h0100, 3, 3'd2, 2'b01, 4'hF);
        checkOutput("incr_bid", 64'(b_id), 64'h3C);
        checkOutput("incr_bresp", 64'(b_resp), 64'd0);
        read_burst(8'h5A, 16'h0100, 3, 3'd2, 2'b01, 1'b0);
        checkOutput("incr_latency", 64'(rd_lat), 64'd2);
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33; exp_words[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("incr_rdata%0d", i), 64'(rd_data[i]), 64'(exp_words[i]));
            checkOutput($sformatf("incr_rlast%0d", i), 64'(rd_last[i]), 64'(i == 3));
            checkOutput($sformatf("incr_rid%0d", i), 64'(rd_id[i]), 64'h5A);
            checkOutput($sformatf("incr_rresp%0d", i), 64'(rd_resp[i]), 64'd0);
        end

        // WRAP len 3 from 0x108 visits 0x108, 0x10C, 0x100, 0x104
        read_burst(8'h12, 16'h0108, 3, 3'd2, 2'b10, 1'b0);
        exp_words[0] = 32'h33; exp_words[1] = 32'h44; exp_words[2] = 32'h11; exp_words[3] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap_rdata%0d", i), 64'(rd_data[i]), 64'(exp_words[i]));
            checkOutput($sformatf("wrap_rresp%0d", i), 64'(rd_resp[i]), 64'd0);
        end

        // WRAP len 2 is illegal: INCR order with SLVERR
        read_burst(8'h13, 16'h0100, 2, 3'd2, 2'b10, 1'b0);
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("wrap2_rdata%0d", i), 64'(rd_data[i]), 64'(exp_words[i]));
            checkOutput($sformatf("wrap2_rresp%0d", i), 64'(rd_resp[i]), 64'b10);
        end

        // Partial strobe merge
        wbuf[0] = 32'hDEADBEEF;
        write_burst(8'h01, 16'h0200, 0, 3'd2, 2'b01, 4'hF);
        wbuf[0] = 32'h12345678;
        write_burst(8'h02, 16'h0200, 0, 3'd2, 2'b01, 4'b0101);
        read_burst(8'h03, 16'h0200, 0, 3'd2, 2'b01, 1'b0);
        checkOutput("strobe_merge", 64'(rd_data[0]), 64'hDE34BE78);

        // Out-of-range word DEPTH, with both neighbours preloaded
        wbuf[0] = 32'hAAAA5555;
        write_burst(8'h04, 16'h0FFC, 0, 3'd2, 2'b01, 4'hF);
        wbuf[0] = 32'h0BADF00D;
        write_burst(8'h05, 16'h0000, 0, 3'd2, 2'b01, 4'hF);
        wbuf[0] = 32'hFFFFFFFF;
        write_burst(8'h06, 16'h1000, 0, 3'd2, 2'b01, 4'hF);
        checkOutput("oor_bresp", 64'(b_resp), 64'b10);
        checkOutput("oor_bid", 64'(b_id), 64'h06);
        read_burst(8'h07, 16'h1000, 0, 3'd2, 2'b01, 1'b0);
        checkOutput("oor_rdata", 64'(rd_data[0]), 64'd0);
        checkOutput("oor_rresp", 64'(rd_resp[0]), 64'b10);
        read_burst(8'h08, 16'h0FFC, 0, 3'd2, 2'b01, 1'b0);
        checkOutput("oor_neighbour_hi", 64'({rd_data[0], rd_resp[0]}), 64'({32'hAAAA5555, 2'b00}));
        read_burst(8'h09, 16'h0000, 0, 3'd2, 2'b01, 1'b0);
        checkOutput("oor_neighbour_lo", 64'({rd_data[0], rd_resp[0]}), 64'({32'h0BADF00D, 2'b00}));

        // 8-beat read with rready toggling
        for (int i = 0; i < 8; i++)
            wbuf[i] = 32'h10000000 + 32'(i) * 32'h0101;
        write_burst(8'h0A, 16'h0300, 7, 3'd2, 2'b01, 4'hF);
        read_burst(8'h0B, 16'h0300, 7, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("stall_rdata%0d", i), 64'(rd_data[i]), 64'(32'h10000000 + 32'(i) * 32'h0101));
            checkOutput($sformatf("stall_rlast%0d", i), 64'(rd_last[i]), 64'(i == 7));
        end

        // Reset in the middle of a write burst
        wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hA1A1A1A1; wbuf[2] = 32'hA2A2A2A2; wbuf[3] = 32'hA3A3A3A3;
        write_burst(8'h0C, 16'h0400, 3, 3'd2, 2'b01, 4'hF);
        send_aw(8'h0D, 16'h0400, 8'd3, 3'd2, 2'b01);
        send_w(32'hB0B0B0B0, 4'hF, 1'b0);
        send_w(32'hB1B1B1B1, 4'hF, 1'b0);
        s_axi_wdata = 32'hB2B2B2B2; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset_valids",
                    64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid}), 64'd0);
        checkOutput("midreset_resp", 64'({s_axi_bresp, s_axi_bid}), 64'd0);
        tick();
        s_axi_wdata = 32'hB3B3B3B3; s_axi_wlast = 1'b1;
        tick();
        checkOutput("midreset_wready_idle", 64'({s_axi_wready, s_axi_bvalid}), 64'd0);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        read_burst(8'h0E, 16'h0400, 3, 3'd2, 2'b01, 1'b0);
        exp_words[0] = 32'hB0B0B0B0; exp_words[1] = 32'hB1B1B1B1;
        exp_words[2] = 32'hA2A2A2A2; exp_words[3] = 32'hA3A3A3A3;
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("midreset_rdata%0d", i), 64'(rd_data[i]), 64'(exp_words[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
